// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain: pops words from a synchronous FIFO in fixed-length bursts
// and presents them on a valid/ready stream with an m_last frame marker.
// A partial burst is flushed once the FIFO has sat non-empty but short of a
// full burst for TIMEOUT cycles. A 2-entry skid buffer hides the FIFO's
// one-cycle read latency so the stream runs at full rate under backpressure.
//
// Optional build macro: FIFO_BURST_DRAIN_STATS_EN adds stat_bursts and
// stat_flushes counters (16-bit, wrapping) on two extra output ports.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a full burst in the FIFO or for the flush timeout
// BURST | issuing pops until blen words have been requested
// DRAIN | all pops issued; waiting for the m_last word to be accepted

module fifo_burst_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 5,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic [CNT_WIDTH-1:0]  fifo_count,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy
`ifdef FIFO_BURST_DRAIN_STATS_EN
    ,
    output logic [15:0]           stat_bursts,
    output logic [15:0]           stat_flushes
`endif
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] BLEN_FULL = CNT_WIDTH'(BURST_LEN);
    localparam logic [TW-1:0]        TMO       = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   blen;
    logic [CNT_WIDTH-1:0]   issued;
    logic [CNT_WIDTH-1:0]   issued_inc;
    logic [TW-1:0]          timer;

    // skid buffer: entry 0 is the head and drives the stream outputs
    logic [1:0]             occ;
    logic [DATA_WIDTH-1:0]  buf_data0;
    logic [DATA_WIDTH-1:0]  buf_data1;
    logic                   buf_last0;
    logic                   buf_last1;
    logic                   inflight;
    logic                   inflight_last;

    logic                   pop;
    logic [2:0]             credit_used;
    logic [2:0]             credit_lim;

`ifdef FIFO_BURST_DRAIN_STATS_EN
    logic                   flush_burst;
`endif

    assign issued_inc = issued + 1'b1;

    assign m_valid = (occ != 2'd0);
    assign m_data  = buf_data0;
    assign m_last  = m_valid && buf_last0;
    assign busy    = (state != IDLE);
    assign pop     = m_valid && m_ready;

    // Words already held or on their way, less the one leaving this cycle,
    // must leave room for the word a new pop would bring in.
    assign credit_used = {1'b0, occ} + {2'b00, inflight};
    assign credit_lim  = 3'd2 + {2'b00, pop};

    // Pop request: only in BURST, only while words remain owed and the
    // skid buffer is guaranteed a free slot when the data arrives.
    always_comb begin
        fifo_rd_en = 1'b0;
        if (state == BURST) begin
            fifo_rd_en = (issued < blen) && !fifo_empty && (credit_used < credit_lim);
        end
    end

    // Sequencing FSM with burst length latch, issue counter and idle timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            blen   <= '0;
            issued <= '0;
            timer  <= '0;
`ifdef FIFO_BURST_DRAIN_STATS_EN
            flush_burst <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_count >= BLEN_FULL) begin
                        blen   <= BLEN_FULL;
                        issued <= '0;
                        timer  <= '0;
                        state  <= BURST;
`ifdef FIFO_BURST_DRAIN_STATS_EN
                        flush_burst <= 1'b0;
`endif
                    end else if (!fifo_empty && (timer == TMO)) begin
                        blen   <= fifo_count;
                        issued <= '0;
                        timer  <= '0;
                        state  <= BURST;
`ifdef FIFO_BURST_DRAIN_STATS_EN
                        flush_burst <= 1'b1;
`endif
                    end else if (fifo_empty) begin
                        timer <= '0;
                    end else if (timer != TMO) begin
                        timer <= timer + 1'b1;
                    end
                end
                BURST: begin
                    if (fifo_empty) begin
                        timer <= '0;
                    end
                    if (fifo_rd_en) begin
                        issued <= issued_inc;
                        if (issued_inc == blen) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        timer <= '0;
                    end
                    if (pop && m_last) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Skid buffer: capture read data one cycle after each pop, shift on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            occ           <= 2'd0;
            buf_data0     <= '0;
            buf_data1     <= '0;
            buf_last0     <= 1'b0;
            buf_last1     <= 1'b0;
        end else begin
            inflight      <= fifo_rd_en;
            inflight_last <= fifo_rd_en && (issued_inc == blen);
            case ({pop, inflight})
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf_data0 <= fifo_rd_data;
                        buf_last0 <= inflight_last;
                    end else begin
                        buf_data0 <= buf_data1;
                        buf_last0 <= buf_last1;
                        buf_data1 <= fifo_rd_data;
                        buf_last1 <= inflight_last;
                    end
                end
                2'b10: begin
                    buf_data0 <= buf_data1;
                    buf_last0 <= buf_last1;
                    occ       <= occ - 1'b1;
                end
                2'b01: begin
                    if (occ == 2'd0) begin
                        buf_data0 <= fifo_rd_data;
                        buf_last0 <= inflight_last;
                    end else begin
                        buf_data1 <= fifo_rd_data;
                        buf_last1 <= inflight_last;
                    end
                    occ <= occ + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FIFO_BURST_DRAIN_STATS_EN
    // Count completed bursts by type when their final word is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_bursts  <= '0;
            stat_flushes <= '0;
        end else if (pop && m_last) begin
            if (flush_burst) begin
                stat_flushes <= stat_flushes + 1'b1;
            end else begin
                stat_bursts <= stat_bursts + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Scoreboard bench for fifo_burst_drain: a behavioural FIFO feeds the DUT,
// stimulus pushes expected words (with last/flush tags derived from the
// grouping rule) into a queue, and a negedge monitor checks every accepted
// word plus the stall-hold and pop-ahead properties.
module tb_fifo_burst_drain;

    localparam int DW  = 8;
    localparam int CW  = 5;
    localparam int BL  = 4;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_empty = 1'b1;
    logic [CW-1:0] fifo_count = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
`ifdef FIFO_BURST_DRAIN_STATS_EN
    logic [15:0]   stat_bursts;
    logic [15:0]   stat_flushes;
`endif

    fifo_burst_drain #(
        .DATA_WIDTH(DW), .CNT_WIDTH(CW), .BURST_LEN(BL), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_empty(fifo_empty), .fifo_count(fifo_count),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .busy(busy)
`ifdef FIFO_BURST_DRAIN_STATS_EN
        , .stat_bursts(stat_bursts), .stat_flushes(stat_flushes)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       flush;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fq[$];
    logic [7:0] wq[$];
    exp_t       mon_e;

    int vectors = 0;
    int miscompares = 0;
    int pops = 0;
    int accepts = 0;
    int mdl_bursts = 0;
    int mdl_flushes = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Behavioural FIFO: one-cycle read latency, writes land at the next edge.
    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
            fifo_count <= '0;
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_rd_en) begin
                if (fq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL fifo_underflow: pop with 0 words, expected at least 1");
                end else begin
                    fifo_rd_data <= fq.pop_front();
                end
            end
            while (wq.size() != 0) fq.push_back(wq.pop_front());
            fifo_count <= CW'(fq.size());
            fifo_empty <= (fq.size() == 0);
        end
    end

    // Monitor: checks accepted words against the scoreboard and stream rules.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall  = 1'b0;
            pops        = 0;
            accepts     = 0;
            mdl_bursts  = 0;
            mdl_flushes = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data", 32'(m_data), 32'(prev_data));
                chk("stall_last", 32'(m_last), 32'(prev_last));
            end
            if (fifo_rd_en) pops++;
            if (m_valid && m_ready) begin
                accepts++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word", m_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("word_data", 32'(m_data), 32'(mon_e.d));
                    chk("word_last", 32'(m_last), 32'(mon_e.last));
                    if (mon_e.last) begin
                        if (mon_e.flush) mdl_flushes++;
                        else mdl_bursts++;
                    end
                end
            end
            if (fifo_rd_en) chk("pop_ahead_le2", 32'(pops - accepts <= 2), 32'd1);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word i of an n-word batch: groups of BL, final partial group is a flush.
    task automatic put_word(input logic [7:0] d, input int i, input int n);
        exp_t e;
        e.d     = d;
        e.last  = ((i % BL) == BL - 1) || (i == n - 1);
        e.flush = (i == n - 1) && ((n % BL) != 0);
        wq.push_back(d);
        exp_q.push_back(e);
    endtask

    // mode 0: ready high, 1: toggle every cycle, 2: random ready
    task automatic wait_drain(input int budget, input int mode);
        int b;
        b = budget;
        while (exp_q.size() != 0 && b > 0) begin
            if (mode == 0) m_ready = 1'b1;
            else if (mode == 1) m_ready = ~m_ready;
            else m_ready = ($urandom_range(0, 9) < 7);
            tick();
            b--;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d words outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        m_ready = 1'b1;
        tick(); tick(); tick();
    endtask

    // Samples m_valid/busy/fifo_rd_en now and after each of the next n-1 edges.
    task automatic record(input int n, output logic [31:0] vv, output logic [31:0] bb,
                          output logic [31:0] rr);
        vv = '0; bb = '0; rr = '0;
        for (int k = 0; k < n; k++) begin
            vv[k] = m_valid;
            bb[k] = busy;
            rr[k] = fifo_rd_en;
            tick();
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] vv, bb, rr, ev;
        int n, gap, b;

        // reset state
        rst = 1'b1;
        m_ready = 1'b0;
        tick(); tick(); tick();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
`ifdef FIFO_BURST_DRAIN_STATS_EN
        chk("rst_stat_bursts", 32'(stat_bursts), 32'd0);
        chk("rst_stat_flushes", 32'(stat_flushes), 32'd0);
`endif
        rst = 1'b0;
        tick();

        // full burst: count visible after edge 1, valid 3 cycles later
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) put_word(8'(8'h11 + i), i, 4);
        record(12, vv, bb, rr);
        ev = '0; for (int k = 4; k <= 7; k++) ev[k] = 1'b1;
        chk("full_valid_pattern", vv, ev);
        ev = '0; for (int k = 2; k <= 7; k++) ev[k] = 1'b1;
        chk("full_busy_pattern", bb, ev);
        ev = '0; for (int k = 2; k <= 5; k++) ev[k] = 1'b1;
        chk("full_rd_en_pattern", rr, ev);
        wait_drain(50, 0);

        // flush: two words, no output until TIMEOUT+4 samples after the write
        put_word(8'hA0, 0, 2);
        put_word(8'hA1, 1, 2);
        record(26, vv, bb, rr);
        ev = '0; ev[TMO + 4] = 1'b1; ev[TMO + 5] = 1'b1;
        chk("flush_valid_pattern", vv, ev);
        wait_drain(50, 0);
        chk("flush_timer_after", 32'(dut.timer), 32'd0);
        chk("flush_busy_after", 32'(busy), 32'd0);
`ifdef FIFO_BURST_DRAIN_STATS_EN
        chk("stat_bursts_1", 32'(stat_bursts), 32'd1);
        chk("stat_flushes_1", 32'(stat_flushes), 32'd1);
`endif

        // backpressure: 8 words, ready toggling every cycle
        for (int i = 0; i < 8; i++) put_word(8'(8'h20 + i), i, 8);
        wait_drain(200, 1);

        // back-to-back: 12 words, three bursts each 3 idle cycles apart
        m_ready = 1'b1;
        for (int i = 0; i < 12; i++) put_word(8'(8'h30 + i), i, 12);
        record(26, vv, bb, rr);
        ev = '0;
        for (int g = 0; g < 3; g++)
            for (int k = 0; k < BL; k++) ev[4 + g * (BL + 3) + k] = 1'b1;
        chk("b2b_valid_pattern", vv, ev);
        wait_drain(50, 0);

        // reset mid-burst after the 2nd accepted word
        m_ready = 1'b1;
        b = accepts;
        for (int i = 0; i < 4; i++) put_word(8'(8'h50 + i), i, 4);
        n = 0;
        while (accepts < b + 2 && n < 40) begin
            tick();
            n++;
        end
        chk("mid_reset_reached", 32'(accepts >= b + 2), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        wq.delete();
        #1;
        chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_m_last", 32'(m_last), 32'd0);
        chk("mid_rst_m_data", 32'(m_data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) put_word(8'(8'h60 + i), i, 4);
        wait_drain(60, 0);

        // randomized batches: words streamed with gaps of 1-3 cycles
        for (int bt = 0; bt < 8; bt++) begin
            n = $urandom_range(1, 14);
            for (int i = 0; i < n; i++) begin
                put_word(8'($urandom_range(0, 255)), i, n);
                gap = $urandom_range(1, 3);
                for (int g = 0; g < gap; g++) begin
                    m_ready = ($urandom_range(0, 9) < 7);
                    tick();
                end
            end
            wait_drain(2000, 2);
        end

`ifdef FIFO_BURST_DRAIN_STATS_EN
        chk("stat_bursts_end", 32'(stat_bursts), 32'(mdl_bursts));
        chk("stat_flushes_end", 32'(stat_flushes), 32'(mdl_flushes));
`endif
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_m_valid", 32'(m_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
